// File: rtl/ysyx_22040931_mem_stage_pkg.sv
// Shared encodings for the MEM stage: load/store op codes, FSM state codes, lane geometry and
// access-size helpers.
package ysyx_22040931_mem_stage_pkg;

  localparam logic [2:0] MemRopLb  = 3'b000;
  localparam logic [2:0] MemRopLh  = 3'b001;
  localparam logic [2:0] MemRopLw  = 3'b010;
  localparam logic [2:0] MemRopLd  = 3'b011;
  localparam logic [2:0] MemRopLbu = 3'b100;
  localparam logic [2:0] MemRopLhu = 3'b101;
  localparam logic [2:0] MemRopLwu = 3'b110;

  localparam logic [2:0] MemWopSb = 3'b000;
  localparam logic [2:0] MemWopSh = 3'b001;
  localparam logic [2:0] MemWopSw = 3'b010;
  localparam logic [2:0] MemWopSd = 3'b011;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBus  = 1'b1;

  localparam int unsigned LaneBytes = 8;
  localparam int unsigned LaneOffW  = 3;

  // log2 of access bytes; loads encode it in memrop[1:0] (111 aliases LD), stores saturate to SD.
  function automatic logic [1:0] access_size(logic wr, logic [2:0] rop, logic [2:0] wop);
    if (wr) begin
      return wop[2] ? 2'd3 : wop[1:0];
    end
    return rop[1:0];
  endfunction

  function automatic logic [LaneBytes-1:0] store_mask(logic [2:0] wop, logic [LaneOffW-1:0] off);
    logic [LaneBytes-1:0] base;
    unique case (access_size(1'b1, 3'b000, wop))
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic logic is_misaligned(logic [1:0] size, logic [LaneOffW-1:0] off);
    unique case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return off[1:0] != 2'b00;
      default: return off != 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040931_load_ext.sv
// Load data alignment: shifts the bus word down to the addressed lane, then truncates and
// sign/zero-extends according to the load op code.
module ysyx_22040931_load_ext
  import ysyx_22040931_mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [LaneOffW-1:0] off_i,
  input  logic [2:0]          memrop_i,
  output logic [DATA_W-1:0]   data_o
);

  logic [DATA_W-1:0] shifted;
  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    data_o = shifted;
    unique case (memrop_i)
      MemRopLb:  data_o = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      MemRopLh:  data_o = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      MemRopLw:  data_o = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
      MemRopLbu: data_o = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      MemRopLhu: data_o = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      MemRopLwu: data_o = {{(DATA_W-32){1'b0}}, shifted[31:0]};
      default:   data_o = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22040931_mem_stage.sv
// MEM stage: one EX result in flight, one data-bus transaction, registered result to WB.
// Define YSYX_22040931_MISALIGN_CHECK_EN to add the mem_misalign output and misalignment check.
module ysyx_22040931_mem_stage
  import ysyx_22040931_mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              w_ena_i,
  input  logic [4:0]        w_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic              mem_ena_i,
  input  logic              mem_wr_i,
  input  logic [2:0]        memrop_i,
  input  logic [2:0]        memwop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [63:0]       pc_i,
  input  logic [31:0]       instr_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              w_ena,
  output logic [4:0]        w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic [63:0]       pc_o,
  output logic [31:0]       instr_o,
`ifdef YSYX_22040931_MISALIGN_CHECK_EN
  output logic              mem_misalign,
`endif
  output logic              dmem_req,
  output logic              dmem_wr,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [LaneBytes-1:0] dmem_wmask,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata
);

  logic [0:0] state_q, state_d;
  logic       out_valid_q, out_valid_d;

  // Request latch, held stable for the whole bus transaction.
  logic                 req_wr_q;
  logic [ADDR_W-1:0]    req_addr_q;
  logic [DATA_W-1:0]    req_wdata_q;
  logic [LaneBytes-1:0] req_mask_q;
  logic [2:0]           req_rop_q;
  logic                 lat_w_ena_q;
  logic [4:0]           lat_w_addr_q;
  logic [DATA_W-1:0]    lat_w_data_q;
  logic [63:0]          lat_pc_q;
  logic [31:0]          lat_instr_q;

  logic              w_ena_q, w_ena_d;
  logic [4:0]        w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [63:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              misalign_q, misalign_d;

  logic              accept, mis_in, go_bus, bus_done, load_out;
  logic [DATA_W-1:0] ext_data;

  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef YSYX_22040931_MISALIGN_CHECK_EN
  assign mis_in = mem_ena_i &&
                  is_misaligned(access_size(mem_wr_i, memrop_i, memwop_i), mem_addr_i[2:0]);
  assign mem_misalign = misalign_q;
`else
  assign mis_in = 1'b0;
`endif

  assign go_bus   = accept && mem_ena_i && !mis_in;
  assign bus_done = (state_q == StBus) && dmem_ack;
  assign load_out = (accept && !go_bus) || bus_done;

  ysyx_22040931_load_ext #(
    .DATA_W (DATA_W)
  ) u_load_ext (
    .rdata_i  (dmem_rdata),
    .off_i    (req_addr_q[2:0]),
    .memrop_i (req_rop_q),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d = state_q;
    if (state_q == StIdle && go_bus) begin
      state_d = StBus;
    end else if (bus_done) begin
      state_d = StIdle;
    end

    out_valid_d = out_valid_q;
    if (load_out) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (bus_done) begin
      w_ena_d    = lat_w_ena_q;
      w_addr_d   = lat_w_addr_q;
      w_data_d   = req_wr_q ? lat_w_data_q : ext_data;
      pc_d       = lat_pc_q;
      instr_d    = lat_instr_q;
      misalign_d = 1'b0;
    end else begin
      w_ena_d    = w_ena_i && !mis_in;
      w_addr_d   = w_addr_i;
      w_data_d   = w_data_i;
      pc_d       = pc_i;
      instr_d    = instr_i;
      misalign_d = mis_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      out_valid_q  <= 1'b0;
      req_wr_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_mask_q   <= '0;
      req_rop_q    <= '0;
      lat_w_ena_q  <= 1'b0;
      lat_w_addr_q <= '0;
      lat_w_data_q <= '0;
      lat_pc_q     <= '0;
      lat_instr_q  <= '0;
      w_ena_q      <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      pc_q         <= '0;
      instr_q      <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      if (go_bus) begin
        req_wr_q     <= mem_wr_i;
        req_addr_q   <= mem_addr_i;
        req_wdata_q  <= mem_data_i << {mem_addr_i[2:0], 3'b000};
        req_mask_q   <= mem_wr_i ? store_mask(memwop_i, mem_addr_i[2:0]) : '0;
        req_rop_q    <= memrop_i;
        lat_w_ena_q  <= w_ena_i;
        lat_w_addr_q <= w_addr_i;
        lat_w_data_q <= w_data_i;
        lat_pc_q     <= pc_i;
        lat_instr_q  <= instr_i;
      end
      if (load_out) begin
        w_ena_q    <= w_ena_d;
        w_addr_q   <= w_addr_d;
        w_data_q   <= w_data_d;
        pc_q       <= pc_d;
        instr_q    <= instr_d;
        misalign_q <= misalign_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign w_ena      = w_ena_q;
  assign w_addr     = w_addr_q;
  assign w_data     = w_data_q;
  assign pc_o       = pc_q;
  assign instr_o    = instr_q;
  assign dmem_req   = (state_q == StBus);
  assign dmem_wr    = req_wr_q;
  assign dmem_addr  = {req_addr_q[ADDR_W-1:3], 3'b000};
  assign dmem_wdata = req_wdata_q;
  assign dmem_wmask = req_mask_q;

endmodule

// File: tb/tb_ysyx_22040931_mem_stage.sv
// Directed bench for the MEM stage: pass-through, loads, stores, backpressure, reset mid-bus.
module tb_ysyx_22040931_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic        w_ena_i;
  logic [4:0]  w_addr_i;
  logic [63:0] w_data_i;
  logic        mem_ena_i, mem_wr_i;
  logic [2:0]  memrop_i, memwop_i;
  logic [31:0] mem_addr_i;
  logic [63:0] mem_data_i, pc_i;
  logic [31:0] instr_i;
  logic        out_valid, out_ready, w_ena;
  logic [4:0]  w_addr;
  logic [63:0] w_data, pc_o;
  logic [31:0] instr_o;
  logic        dmem_req, dmem_wr, dmem_ack;
  logic [31:0] dmem_addr;
  logic [63:0] dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wmask;
`ifdef YSYX_22040931_MISALIGN_CHECK_EN
  logic        mem_misalign;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  ysyx_22040931_mem_stage dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .w_ena_i    (w_ena_i),
    .w_addr_i   (w_addr_i),
    .w_data_i   (w_data_i),
    .mem_ena_i  (mem_ena_i),
    .mem_wr_i   (mem_wr_i),
    .memrop_i   (memrop_i),
    .memwop_i   (memwop_i),
    .mem_addr_i (mem_addr_i),
    .mem_data_i (mem_data_i),
    .pc_i       (pc_i),
    .instr_i    (instr_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .w_ena      (w_ena),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .pc_o       (pc_o),
    .instr_o    (instr_o),
`ifdef YSYX_22040931_MISALIGN_CHECK_EN
    .mem_misalign (mem_misalign),
`endif
    .dmem_req   (dmem_req),
    .dmem_wr    (dmem_wr),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wmask (dmem_wmask),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic nonmem(input logic [63:0] data);
    @(negedge clock);
    in_valid = 1'b1; mem_ena_i = 1'b0; w_ena_i = 1'b1; w_addr_i = 5'd3; w_data_i = data;
    pc_i = 64'h8000_0100; instr_i = 32'h0000_0013;
  endtask

  task automatic load_op(input string tag, input logic [2:0] rop, input logic [31:0] addr,
                         input logic [63:0] rdata, input int lat, input logic [63:0] exp);
    @(negedge clock);
    in_valid = 1'b1; mem_ena_i = 1'b1; mem_wr_i = 1'b0; memrop_i = rop; mem_addr_i = addr;
    w_ena_i = 1'b1; w_addr_i = 5'd9; w_data_i = 64'hDEAD; out_ready = 1'b1;
    @(posedge clock); #1;
    check({tag, " req"}, 64'(dmem_req), 64'd1);
    check({tag, " addr"}, 64'(dmem_addr), 64'({addr[31:3], 3'b000}));
    check({tag, " in_ready"}, 64'(in_ready), 64'd0);
    @(negedge clock);
    in_valid = 1'b0; mem_ena_i = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(posedge clock); #1;
      check({tag, " held"}, {62'd0, dmem_req, out_valid}, 64'd2);
      @(negedge clock);
    end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    @(posedge clock); #1;
    check({tag, " done"}, {61'd0, out_valid, dmem_req, w_ena}, 64'd5);
    check({tag, " data"}, w_data, exp);
    @(negedge clock);
    dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  task automatic store_op(input string tag, input logic [2:0] wop, input logic [31:0] addr,
                          input logic [63:0] data, input logic [7:0] mask,
                          input logic [63:0] wdata);
    @(negedge clock);
    in_valid = 1'b1; mem_ena_i = 1'b1; mem_wr_i = 1'b1; memwop_i = wop; mem_addr_i = addr;
    mem_data_i = data; w_ena_i = 1'b0; w_data_i = 64'h5555; out_ready = 1'b1;
    @(posedge clock); #1;
    check({tag, " req/wr"}, {62'd0, dmem_req, dmem_wr}, 64'd3);
    check({tag, " mask"}, 64'(dmem_wmask), 64'(mask));
    check({tag, " wdata"}, dmem_wdata, wdata);
    @(negedge clock);
    in_valid = 1'b0; mem_ena_i = 1'b0; dmem_ack = 1'b1;
    @(posedge clock); #1;
    check({tag, " done"}, {61'd0, out_valid, dmem_req, w_ena}, 64'd4);
    check({tag, " wb"}, w_data, 64'h5555);
    @(negedge clock);
    dmem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; w_ena_i = 1'b0; w_addr_i = '0; w_data_i = '0;
    mem_ena_i = 1'b0; mem_wr_i = 1'b0; memrop_i = '0; memwop_i = '0; mem_addr_i = '0;
    mem_data_i = '0; pc_i = '0; instr_i = '0; out_ready = 1'b1; dmem_ack = 1'b0;
    dmem_rdata = '0;
    #12;
    check("rst outs", {59'd0, out_valid, dmem_req, dmem_wr, w_ena, in_ready}, 64'd1);
    check("rst data", w_data | 64'(dmem_wmask) | 64'(dmem_addr), 64'd0);
    @(negedge clock); reset = 1'b0;

    // Non-memory pass-through, then drain.
    nonmem(64'h1234);
    @(posedge clock); #1;
    check("nm valid", {62'd0, out_valid, w_ena}, 64'd3);
    check("nm data", w_data, 64'h1234);
    check("nm pc", pc_o, 64'h8000_0100);
    @(negedge clock); in_valid = 1'b0;
    @(posedge clock); #1;
    check("nm drain", 64'(out_valid), 64'd0);

    load_op("lb", 3'b000, 32'h8000_0003, 64'h0000_0000_FF00_0000, 2, 64'hFFFF_FFFF_FFFF_FFFF);
    load_op("lbu", 3'b100, 32'h8000_0003, 64'h0000_0000_FF00_0000, 2, 64'h0000_0000_0000_00FF);
    load_op("lh", 3'b001, 32'h8000_0006, 64'h8001_0000_0000_0000, 0, 64'hFFFF_FFFF_FFFF_8001);
    load_op("lhu", 3'b101, 32'h8000_0002, 64'h0000_0000_BEEF_0000, 1, 64'h0000_0000_0000_BEEF);
    load_op("lw", 3'b010, 32'h8000_0004, 64'h8000_0000_0000_0000, 0, 64'hFFFF_FFFF_8000_0000);
    load_op("lwu", 3'b110, 32'h8000_0000, 64'hFFFF_FFFF_8765_4321, 0, 64'h0000_0000_8765_4321);
    load_op("ld7", 3'b111, 32'h8000_0008, 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF);

    store_op("sh", 3'b001, 32'h8000_0006, 64'hABCD, 8'hC0, 64'hABCD_0000_0000_0000);
    store_op("sb", 3'b000, 32'h8000_0001, 64'h5A, 8'h02, 64'h0000_0000_0000_5A00);
    store_op("sw", 3'b010, 32'h8000_0004, 64'hCAFE_BABE, 8'hF0, 64'hCAFE_BABE_0000_0000);
    store_op("sd5", 3'b101, 32'h8000_0000, 64'h1122_3344_5566_7788, 8'hFF,
             64'h1122_3344_5566_7788);
`ifndef YSYX_22040931_MISALIGN_CHECK_EN
    store_op("swx", 3'b010, 32'h8000_0006, 64'h1122_3344, 8'hC0, 64'h3344_0000_0000_0000);
`endif

    // Backpressure: hold result A, offer B, then accept B on the same edge A drains.
    @(negedge clock); out_ready = 1'b0;
    nonmem(64'hA);
    @(posedge clock); #1;
    check("bp a", w_data, 64'hA);
    check("bp stall", {62'd0, out_valid, in_ready}, 64'd2);
    @(negedge clock); w_data_i = 64'hB;
    @(posedge clock); #1;
    check("bp hold", w_data, 64'hA);
    @(negedge clock); out_ready = 1'b1; #1;
    check("bp rdy", 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    check("bp b", {63'd0, out_valid}, 64'd1);
    check("bp b data", w_data, 64'hB);
    @(negedge clock); in_valid = 1'b0;

    // Reset while the bus transaction is outstanding.
    @(negedge clock);
    in_valid = 1'b1; mem_ena_i = 1'b1; mem_wr_i = 1'b0; memrop_i = 3'b011;
    mem_addr_i = 32'h8000_0010;
    @(posedge clock); #1;
    check("rb req", 64'(dmem_req), 64'd1);
    @(negedge clock); in_valid = 1'b0; mem_ena_i = 1'b0; #2;
    reset = 1'b1; #1;
    check("rb drop", {61'd0, dmem_req, out_valid, in_ready}, 64'd1);
    @(negedge clock); reset = 1'b0;

    // Stray ack while idle is ignored.
    dmem_ack = 1'b1; dmem_rdata = 64'hFFFF;
    @(posedge clock); #1;
    check("stray ack", {62'd0, out_valid, dmem_req}, 64'd0);
    @(negedge clock); dmem_ack = 1'b0;

`ifdef YSYX_22040931_MISALIGN_CHECK_EN
    @(negedge clock);
    in_valid = 1'b1; mem_ena_i = 1'b1; mem_wr_i = 1'b0; memrop_i = 3'b010;
    mem_addr_i = 32'h0000_0002; w_ena_i = 1'b1;
    @(posedge clock); #1;
    check("mis", {60'd0, dmem_req, out_valid, mem_misalign, w_ena}, 64'd6);
    nonmem(64'h77);
    @(posedge clock); #1;
    check("mis clr", {62'd0, mem_misalign, w_ena}, 64'd1);
    @(negedge clock); in_valid = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
